cla_iter_divider: RTL and testbench
===================================

Name: cla_iter_divider

Overview:
Multi-cycle 32-bit integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU operations. It sits directly upstream of the 32-bit carry-lookahead adder module `cla`. It instantiates one `cla` and drives it each cycle with a trial subtraction (a + ~b + 1), then consumes `sum` and `cout_final` to decide each quotient bit. The execute stage stalls on `in_ready`/`out_valid` while the divide runs.

Parameters:
- WIDTH, 32, operand width. Only 32 is legal, matching `cla`.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request; equals (state == IDLE)
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  32  rs1 value
- divisor  in  32  rs2 value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  32  quotient or remainder, selected by op
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, out_valid = 0, result = 0, busy = 0, counter = 0.
  - Internal remainder, quotient and operand registers = 0.
  - in_ready reads 1 during reset, but inputs are ignored until rst_n is high.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Accept when in_valid && in_ready at edge T.
  - Latch op, plus signs sa = dividend[31] and sb = divisor[31] (signed ops only; forced to 0 for DIVU/REMU).
  - Latch magnitudes: |x| = ~x + 1 when the sign bit is set, else x.
- Special cases, decided at edge T; IDLE goes directly to DONE, so out_valid is high after edge T:
  - divisor == 0: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = dividend.
  - DIV/REM with dividend == 0x80000000 and divisor == 0xFFFFFFFF: DIV result = 0x80000000; REM result = 0.
- Normal path: IDLE -> CALC with counter = 0. Edges T+1 .. T+32 each perform one restoring iteration:
  - Shift: {rem, quo} <= {rem, quo} << 1.
  - Trial: `cla` a = {rem[30:0], quo[31]}, b = ~divisor_mag, cin = 1.
  - If cout_final == 1 (no borrow): rem <= sum and quotient LSB = 1.
  - Otherwise: rem <= the shifted value and quotient LSB = 0.
  - Counter increments each iteration. At the edge where counter == 31, go to DONE.
- Entering DONE from CALC (edge T+32): result is registered at that edge.
  - DIV/DIVU: quo, negated if sa ^ sb (DIV only).
  - REM/REMU: rem, negated if sa (REM only).
  - out_valid is high after edge T+32, giving a fixed 32-cycle latency.
- DONE:
  - out_valid = 1; result and out_valid hold stable while out_ready == 0.
  - On out_valid && out_ready: go to IDLE, out_valid = 0, result holds its last value.
  - in_ready rises in the cycle after the handshake. A new request is never accepted in the same cycle as the result handshake.
- Timing constraints:
  - in_valid and inputs are ignored outside IDLE.
  - Operands must be stable only at the accepting edge.
- Mid-operation: no abort or flush input. Only rst_n cancels an operation. Asserting rst_n low in CALC or DONE returns all outputs to their reset values immediately, without waiting for a clock edge.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^32.
  - The negated-magnitude case |0x80000000| = 0x80000000 is handled as an unsigned value.
  - Restoring division is exact for all unsigned magnitudes.
- Adder usage: a single `cla` instance performs the trial subtraction. Negations may use dedicated incrementers; they must not add a second 32-cycle path.

Test Plan:
- DIVU 100 / 7, out_ready = 1 → out_valid rises exactly 32 edges after accept, result = 14; REMU of the same operands → 2.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); REM of the same operands → 0xFFFFFFFF (-1); REM 7 / 0xFFFFFFFE → 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; both with out_valid high after the accepting edge (1-cycle latency).
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both 1-cycle latency.
- Backpressure: DIVU 0xFFFFFFFF / 1 with out_ready held low 10 cycles after out_valid.
  - Result must stay 0xFFFFFFFF, out_valid high, in_ready low, in_valid pulses ignored.
  - Raise out_ready → in_ready rises on the following cycle.
- Reset mid-CALC: assert rst_n low after the 16th iteration edge.
  - out_valid and busy go to 0 immediately.
  - After release, DIVU 9 / 3 → 3 with normal latency.

Source files
------------

// File: rtl/cla_iter_divider.sv
// ============================================================================
// cla_iter_divider : 32-cycle restoring divide/remainder unit (RV32M DIV/DIVU/REM/REMU)
//                    built around a single carry-lookahead adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cla (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout_final
);
   logic [8:0] w_gc;

   assign w_gc[0]    = cin;
   assign cout_final = w_gc[8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_grp
         logic [3:0] w_g;
         logic [3:0] w_p;
         logic [4:0] w_c;

         assign w_g    = a[4*gi +: 4] & b[4*gi +: 4];
         assign w_p    = a[4*gi +: 4] ^ b[4*gi +: 4];
         assign w_c[0] = w_gc[gi];
         assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
         assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & w_c[0]);
         assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0])
                       | (&w_p[2:0] & w_c[0]);
         assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1])
                       | (&w_p[3:1] & w_g[0]) | (&w_p[3:0] & w_c[0]);
         assign sum[4*gi +: 4] = w_p ^ w_c[3:0];
         assign w_gc[gi+1]     = w_c[4];
      end
   endgenerate
endmodule

module cla_iter_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);
   localparam logic [1:0]       S_IDLE = 2'd0;
   localparam logic [1:0]       S_CALC = 2'd1;
   localparam logic [1:0]       S_DONE = 2'd2;
   localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] c_LAST = {CNT_W{1'b1}};

   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dmag, r_result;
   logic             r_is_rem, r_sa, r_sb;

   logic             w_accept, w_sa, w_sb, w_div_zero, w_ovf, w_special, w_last;
   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_special_res;
   logic [WIDTH-1:0] w_trial_a, w_trial_b, w_sum, w_rem_nxt, w_quo_nxt;
   logic [WIDTH-1:0] w_quo_fin, w_rem_fin, w_calc_res;
   logic             w_cout, w_take;

   // Request decode: signs only matter for the signed ops (op[0] == 0)
   assign w_accept   = in_valid && in_ready;
   assign w_sa       = ~op[0] & dividend[WIDTH-1];
   assign w_sb       = ~op[0] & divisor[WIDTH-1];
   assign w_dvd_mag  = w_sa ? (~dividend + c_ONE) : dividend;
   assign w_dvs_mag  = w_sb ? (~divisor + c_ONE) : divisor;
   assign w_div_zero = (divisor == '0);
   assign w_ovf      = ~op[0] && (dividend == c_MIN) && (divisor == '1);
   assign w_special  = w_div_zero | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div_zero)
         w_special_res = op[1] ? dividend : '1;
      else
         w_special_res = op[1] ? '0 : c_MIN;
   end

   // One restoring step: trial-subtract the divisor magnitude via the adder
   assign w_trial_a = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
   assign w_trial_b = ~r_dmag;

   cla u_cla (
      .a          (w_trial_a),
      .b          (w_trial_b),
      .cin        (1'b1),
      .sum        (w_sum),
      .cout_final (w_cout)
   );

   // A set rem MSB means the shifted remainder exceeds 2^32 > divisor, so the
   // subtract always succeeds even though the 32-bit adder loses that bit.
   assign w_take     = w_cout | r_rem[WIDTH-1];
   assign w_rem_nxt  = w_take ? w_sum : w_trial_a;
   assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_take};
   assign w_last     = (r_cnt == c_LAST);
   assign w_quo_fin  = (r_sa ^ r_sb) ? (~w_quo_nxt + c_ONE) : w_quo_nxt;
   assign w_rem_fin  = r_sa ? (~w_rem_nxt + c_ONE) : w_rem_nxt;
   assign w_calc_res = r_is_rem ? w_rem_fin : w_quo_fin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
         S_CALC:  if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      busy      = (r_state == S_CALC) || (r_state == S_DONE);
      out_valid = (r_state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dmag   <= '0;
         r_result <= '0;
         r_is_rem <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_accept) begin
            r_is_rem <= op[1];
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_dmag   <= w_dvs_mag;
            r_quo    <= w_dvd_mag;
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_special)
               r_result <= w_special_res;
         end
      end else if (r_state == S_CALC) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last)
            r_result <= w_calc_res;
      end
   end

   assign result = r_result;
endmodule

`default_nettype wire

// File: tb/tb_cla_iter_divider.sv
// ============================================================================
// tb_cla_iter_divider : scoreboard bench for cla_iter_divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cla_iter_divider;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [1:0]  op;
   logic [31:0] dividend, divisor, result;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] q_exp[$];

   always #5 clk = ~clk;

   cla_iter_divider #(.WIDTH(32), .CNT_W(5)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'b00:   return $signed(a) / $signed(b);
         2'b01:   return a / b;
         2'b10:   return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      int lat;
      logic [31:0] exp;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1'b1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      op        = o;
      dividend  = a;
      divisor   = b;
      q_exp.push_back(model(o, a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, is_special(o, a, b) ? 0 : 32);
      exp = q_exp.pop_front();
      check("result", result, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = i[0];
         @(posedge clk);
         #1;
         check("bp_result", result, exp);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after", in_ready, 1'b1);
      check("out_valid_after", out_valid, 1'b0);
      check("result_held", result, exp);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 2'b00;
      dividend  = '0;
      divisor   = '0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_result", result, 32'd0);
      check("rst_in_ready", in_ready, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b01, 32'd100, 32'd7, 0);
      run_op(2'b11, 32'd100, 32'd7, 0);
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
      run_op(2'b01, 32'd5, 32'd0, 0);
      run_op(2'b10, 32'd5, 32'd0, 0);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 10);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 0);
      run_op(2'b01, 32'hFFFF_FFFE, 32'hC000_0000, 0);
      run_op(2'b00, 32'h8000_0000, 32'd3, 0);

      // Abort a divide half-way with reset
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b01;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_result", result, 32'd0);
      check("abort_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b01, 32'd9, 32'd3, 0);

      for (int k = 0; k < 12; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         if (k[1:0] == 2'd1) rb = rb >> $urandom_range(31, 0);
         run_op(2'($urandom_range(3, 0)), ra, rb, k[2] ? 2 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
